// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS core-to-Avalon bus arbiter: FSM states, request
// registers, registered bus image and the access-ordering helpers.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRST   = 2'd1,
    SECOND  = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_INSTR = 2'd1,
    ACC_DATA  = 2'd2
  } acc_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic [31:0] ip_address;
    logic [31:0] dp_address;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        read_ip;
    logic        read_dp;
    logic        write_dp;
  } arb_req_t;

  typedef struct packed {
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
  } avl_bus_t;

  // The access served in FIRST; data goes first unless instr_first is set.
  function automatic acc_t first_access(input arb_req_t r, input logic instr_first);
    logic need_i;
    logic need_d;
    need_i = r.read_ip;
    need_d = r.read_dp | r.write_dp;
    if (need_i && need_d) return instr_first ? ACC_INSTR : ACC_DATA;
    else if (need_i)      return ACC_INSTR;
    else if (need_d)      return ACC_DATA;
    else                  return ACC_NONE;
  endfunction

  function automatic acc_t second_access(input arb_req_t r, input logic instr_first);
    if (r.read_ip && (r.read_dp | r.write_dp)) return instr_first ? ACC_DATA : ACC_INSTR;
    else                                       return ACC_NONE;
  endfunction

  // Bus image for one access; a data write wins over a simultaneous data read.
  function automatic avl_bus_t bus_drive(input acc_t acc, input arb_req_t r);
    avl_bus_t b;
    b = '0;
    case (acc)
      ACC_INSTR: begin
        b.address    = r.ip_address;
        b.read       = 1'b1;
        b.byteenable = BE_WORD;
      end
      ACC_DATA: begin
        b.address    = r.dp_address;
        b.write      = r.write_dp;
        b.read       = r.read_dp & ~r.write_dp;
        b.writedata  = r.writedata;
        b.byteenable = r.byteenable;
      end
      default: ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mips_arb_ibuf.sv
// One-word instruction buffer for mips_bus_arbiter (used only when
// MIPS_ARB_IBUF_EN is defined). Refilled by every bus fetch, killed by writes.
module mips_arb_ibuf (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_addr,
  output logic        lookup_hit,
  output logic [31:0] lookup_data,
  input  logic        fill_en,
  input  logic [31:0] fill_addr,
  input  logic [31:0] fill_data,
  input  logic        inval_en,
  input  logic [31:0] inval_addr
);

  logic        ibuf_valid;
  logic [31:0] ibuf_addr;
  logic [31:0] ibuf_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ibuf_valid <= 1'b0;
      ibuf_addr  <= '0;
      ibuf_data  <= '0;
    end else if (fill_en) begin
      ibuf_valid <= 1'b1;
      ibuf_addr  <= fill_addr;
      ibuf_data  <= fill_data;
    end else if (inval_en && (inval_addr == ibuf_addr)) begin
      ibuf_valid <= 1'b0;
    end
  end

  assign lookup_hit  = ibuf_valid && (lookup_addr == ibuf_addr);
  assign lookup_data = ibuf_data;

endmodule

// File: rtl/mips_bus_arbiter.sv
// Serialises one cycle's instruction and data requests onto a single Avalon-MM
// master, stalling the core until both complete. MIPS_ARB_IBUF_EN adds a fetch buffer.
module mips_bus_arbiter #(
  parameter int INSTR_FIRST = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        stall,
  input  logic [31:0] ip_address,
  input  logic        read_ip,
  output logic [31:0] ip_data,
  input  logic [31:0] dp_address,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  input  logic        read_dp,
  input  logic        write_dp,
  output logic [31:0] dp_data,
  output logic [31:0] avl_address,
  output logic        avl_read,
  output logic        avl_write,
  output logic [31:0] avl_writedata,
  output logic [3:0]  avl_byteenable,
  input  logic [31:0] avl_readdata,
  input  logic        avl_waitrequest
);

  import mips_bus_pkg::*;

  localparam logic INSTR_FIRST_B = (INSTR_FIRST != 0);

  arb_state_t  state, state_nxt;
  arb_req_t    req, req_in;
  avl_bus_t    bus_q, bus_nxt;
  acc_t        cur_acc, nxt_acc;
  logic        any_req;
  logic        ibuf_hit;
  logic [31:0] ibuf_rdata;
  logic        done;

`ifdef MIPS_ARB_IBUF_EN
  logic ibuf_lookup_hit;

  mips_arb_ibuf u_ibuf (
    .clk         (clk),
    .rst         (rst),
    .lookup_addr (ip_address),
    .lookup_hit  (ibuf_lookup_hit),
    .lookup_data (ibuf_rdata),
    .fill_en     (done && (cur_acc == ACC_INSTR)),
    .fill_addr   (req.ip_address),
    .fill_data   (avl_readdata),
    .inval_en    (done && (cur_acc == ACC_DATA) && req.write_dp),
    .inval_addr  (req.dp_address)
  );

  assign ibuf_hit = read_ip && ibuf_lookup_hit;
`else
  assign ibuf_hit   = 1'b0;
  assign ibuf_rdata = '0;
`endif

  assign any_req = read_ip | read_dp | write_dp;

  // A buffered fetch is dropped from the request so it never reaches the bus.
  always_comb begin
    req_in.ip_address = ip_address;
    req_in.dp_address = dp_address;
    req_in.writedata  = writedata;
    req_in.byteenable = byteenable;
    req_in.read_ip    = read_ip & ~ibuf_hit;
    req_in.read_dp    = read_dp;
    req_in.write_dp   = write_dp;
  end

  // State register and the registered bus outputs.
  // NOTE: reset here is synchronous -- it is only sampled inside the clocked
  // block, so there is no rst term in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      bus_q <= '0;
    end else begin
      state <= state_nxt;
      bus_q <= bus_nxt;
    end
  end

  // Next state, plus which access is on the bus now and which one follows.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_nxt = state;
    cur_acc   = ACC_NONE;
    nxt_acc   = ACC_NONE;
    case (state)
      IDLE: begin
        if (any_req) begin
          nxt_acc   = first_access(req_in, INSTR_FIRST_B);
          state_nxt = (nxt_acc == ACC_NONE) ? RELEASE : FIRST;
        end
      end
      FIRST: begin
        cur_acc = first_access(req, INSTR_FIRST_B);
        if (avl_waitrequest) begin
          nxt_acc = cur_acc;
        end else if (second_access(req, INSTR_FIRST_B) != ACC_NONE) begin
          nxt_acc   = second_access(req, INSTR_FIRST_B);
          state_nxt = SECOND;
        end else begin
          state_nxt = RELEASE;
        end
      end
      SECOND: begin
        cur_acc = second_access(req, INSTR_FIRST_B);
        if (avl_waitrequest) nxt_acc = cur_acc;
        else                 state_nxt = RELEASE;
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    bus_nxt = bus_drive(nxt_acc, (state == IDLE) ? req_in : req);
  end

  assign done = (cur_acc != ACC_NONE) && !avl_waitrequest;

  // Core hold: combinational on the request in IDLE, state-derived elsewhere.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:          stall = any_req;
      FIRST, SECOND: stall = 1'b1;
      default:       stall = 1'b0;
    endcase
  end

  // Request registers and read-data capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      req     <= '0;
      ip_data <= '0;
      dp_data <= '0;
    end else begin
      if ((state == IDLE) && any_req) req <= req_in;
      if ((state == IDLE) && ibuf_hit) ip_data <= ibuf_rdata;
      if (done && (cur_acc == ACC_INSTR)) ip_data <= avl_readdata;
      if (done && (cur_acc == ACC_DATA) && req.read_dp && !req.write_dp)
        dp_data <= avl_readdata;
    end
  end

  assign avl_address    = bus_q.address;
  assign avl_read       = bus_q.read;
  assign avl_write      = bus_q.write;
  assign avl_writedata  = bus_q.writedata;
  assign avl_byteenable = bus_q.byteenable;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: directed scenarios plus random
// transactions against a transaction-level model with a random-wait slave.
module tb_mips_bus_arbiter;

  localparam int TB_INSTR_FIRST = 0;
`ifdef MIPS_ARB_IBUF_EN
  localparam bit IBUF = 1'b1;
`else
  localparam bit IBUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] ip_address;
  logic        read_ip;
  logic [31:0] ip_data;
  logic [31:0] dp_address;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        read_dp;
  logic        write_dp;
  logic [31:0] dp_data;
  logic [31:0] avl_address;
  logic        avl_read;
  logic        avl_write;
  logic [31:0] avl_writedata;
  logic [3:0]  avl_byteenable;
  logic [31:0] avl_readdata;
  logic        avl_waitrequest;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.INSTR_FIRST(TB_INSTR_FIRST)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .ip_address     (ip_address),
    .read_ip        (read_ip),
    .ip_data        (ip_data),
    .dp_address     (dp_address),
    .writedata      (writedata),
    .byteenable     (byteenable),
    .read_dp        (read_dp),
    .write_dp       (write_dp),
    .dp_data        (dp_data),
    .avl_address    (avl_address),
    .avl_read       (avl_read),
    .avl_write      (avl_write),
    .avl_writedata  (avl_writedata),
    .avl_byteenable (avl_byteenable),
    .avl_readdata   (avl_readdata),
    .avl_waitrequest(avl_waitrequest)
  );

  typedef struct {
    bit          instr;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
  } bacc_t;

  int n_cmp = 0;
  int n_err = 0;
  bit abort = 1'b0;

  // Reference state: last delivered results and the fetch buffer contents.
  logic [31:0] ref_ip = '0;
  logic [31:0] ref_dp = '0;
  logic        ref_iv = 1'b0;
  logic [31:0] ref_ia = '0;
  logic [31:0] ref_id = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic scramble();
    ip_address = $urandom;
    dp_address = $urandom;
    writedata  = $urandom;
    byteenable = 4'($urandom);
    read_ip    = 1'($urandom);
    read_dp    = 1'($urandom);
    write_dp   = 1'($urandom);
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(3, 0))
      0:       return 32'h400;
      1:       return 32'h404;
      2:       return 32'h408;
      default: return $urandom;
    endcase
  endfunction

  // One core cycle's request. Entered and left at posedge+1 of an IDLE cycle.
  // w0/w1 are wait states for the first/second bus access (-1 = random);
  // rd0 is the read data returned by the first bus access.
  task automatic txn(input logic r_ip, input logic [31:0] ip, input logic r_dp,
                     input logic w_dp, input logic [31:0] dp, input logic [31:0] wd,
                     input logic [3:0] be, input int w0, input int w1,
                     input logic [31:0] rd0);
    bacc_t       q[$];
    bacc_t       ia, da;
    int          wv[2];
    int          idx, wl, cyc, exp_cyc;
    logic        hit;
    logic [31:0] exp_ip, exp_dp, rd;
    bit          released;

    wv[0] = (w0 < 0) ? $urandom_range(3, 0) : w0;
    wv[1] = (w1 < 0) ? $urandom_range(3, 0) : w1;
    scramble();
    read_ip = r_ip; ip_address = ip;
    read_dp = r_dp; write_dp = w_dp; dp_address = dp;
    writedata = wd; byteenable = be;

    hit = IBUF && r_ip && ref_iv && (ref_ia == ip);
    ia = '{instr: 1'b1, rd: 1'b1, wr: 1'b0, addr: ip, wd: 32'h0, be: 4'hF};
    da = '{instr: 1'b0, rd: r_dp && !w_dp, wr: w_dp, addr: dp, wd: wd, be: be};
    if (r_ip && !hit) q.push_back(ia);
    if (r_dp || w_dp) begin
      if (TB_INSTR_FIRST != 0) q.push_back(da);
      else                     q.push_front(da);
    end
    exp_cyc = 1;
    foreach (q[i]) exp_cyc += 1 + wv[i];

    #1;
    check("idle_stall", stall, r_ip | r_dp | w_dp);
    check("idle_avl_read", avl_read, 0);
    check("idle_avl_write", avl_write, 0);
    if (!(r_ip | r_dp | w_dp)) begin
      @(posedge clk); #1;
      return;
    end

    exp_ip   = hit ? ref_id : ref_ip;
    exp_dp   = ref_dp;
    idx      = 0;
    wl       = (q.size() > 0) ? wv[0] : 0;
    cyc      = 0;
    released = 1'b0;
    while (!released && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      scramble();
      avl_waitrequest = 1'($urandom);
      avl_readdata    = $urandom;
      if (!stall) begin
        released = 1'b1;
      end else if (idx < q.size()) begin
        check($sformatf("acc%0d_address", idx), avl_address, q[idx].addr);
        check($sformatf("acc%0d_read", idx), avl_read, q[idx].rd);
        check($sformatf("acc%0d_write", idx), avl_write, q[idx].wr);
        check($sformatf("acc%0d_byteenable", idx), avl_byteenable, q[idx].be);
        check($sformatf("acc%0d_writedata", idx), avl_writedata, q[idx].wd);
        if (wl > 0) begin
          avl_waitrequest = 1'b1;
          wl--;
        end else begin
          rd = (idx == 0) ? rd0 : $urandom;
          avl_waitrequest = 1'b0;
          avl_readdata    = rd;
          if (q[idx].instr) begin
            exp_ip = rd;
            ref_iv = 1'b1; ref_ia = q[idx].addr; ref_id = rd;
          end else if (q[idx].wr) begin
            if (ref_ia == q[idx].addr) ref_iv = 1'b0;
          end else begin
            exp_dp = rd;
          end
          idx++;
          if (idx < q.size()) wl = wv[idx];
        end
      end else begin
        check("extra_stall", stall, 0);
      end
    end

    if (!released) begin
      check("release_timeout", stall, 0);
      abort = 1'b1;
      return;
    end
    check("release_cycle", cyc, exp_cyc);
    check("access_count", idx, q.size());
    check("release_ip_data", ip_data, exp_ip);
    check("release_dp_data", dp_data, exp_dp);
    check("release_avl_read", avl_read, 0);
    check("release_avl_write", avl_write, 0);
    ref_ip = exp_ip;
    ref_dp = exp_dp;
    @(posedge clk); #1;
    read_ip = 1'b0; read_dp = 1'b0; write_dp = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    read_ip = 1'b0; read_dp = 1'b0; write_dp = 1'b0;
    ip_address = '0; dp_address = '0; writedata = '0; byteenable = '0;
    avl_readdata = '0; avl_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", stall, 0);
    check("reset_avl_read", avl_read, 0);
    check("reset_avl_write", avl_write, 0);
    check("reset_avl_address", avl_address, 0);
    check("reset_avl_byteenable", avl_byteenable, 0);
    check("reset_ip_data", ip_data, 0);
    check("reset_dp_data", dp_data, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Fetch only, zero wait.
    txn(1, 32'hBFC00000, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h24020005);
    // Fetch plus half-word store: write first, then the fetch.
    txn(1, 32'hBFC00004, 0, 1, 32'h1000, 32'hDEADBEEF, 4'b0011, 0, 0, 32'h0);
    // Load with three wait states.
    txn(0, 32'h0, 1, 0, 32'h2000, 32'h0, 4'hF, 3, 0, 32'h12345678);
    // Read and write both requested: write only, dp_data untouched.
    txn(0, 32'h0, 1, 1, 32'h3000, 32'hCAFEF00D, 4'hF, 1, 0, 32'hA5A5A5A5);
    // Fetch buffer: repeated fetch, store to it, fetch again.
    txn(1, 32'h400, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h11111111);
    txn(1, 32'h400, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h22222222);
    txn(0, 32'h0, 0, 1, 32'h400, 32'h33333333, 4'hF, 0, 0, 32'h0);
    txn(1, 32'h400, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h44444444);
    txn(1, 32'h400, 1, 0, 32'h500, 32'h0, 4'hF, 2, 1, 32'h55555555);

    // Reset in the middle of a stalled load.
    read_dp = 1'b1; dp_address = 32'h2000; byteenable = 4'hF;
    @(posedge clk); #1;
    read_dp = 1'b0;
    avl_waitrequest = 1'b1;
    check("mid_reset_pre_read", avl_read, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_reset_avl_read", avl_read, 0);
    check("mid_reset_stall", stall, 0);
    check("mid_reset_dp_data", dp_data, 0);
    check("mid_reset_ip_data", ip_data, 0);
    rst = 1'b1;
    avl_waitrequest = 1'b0;
    ref_ip = '0; ref_dp = '0; ref_iv = 1'b0;
    @(posedge clk); #1;
    txn(1, 32'h400, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h66666666);

    for (int i = 0; i < 150 && !abort; i++) begin
      logic r_ip, r_dp, w_dp;
      r_ip = ($urandom_range(3, 0) != 0);
      r_dp = 1'($urandom);
      w_dp = ($urandom_range(3, 0) == 0);
      txn(r_ip, pick_addr(), r_dp, w_dp, pick_addr(), $urandom, 4'($urandom),
          -1, -1, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
